// File: rtl/pipe_pkg.sv
// Shared types and constants for the LEGv8 pipeline hazard controller.
package pipe_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned ST_W  = 2;

    typedef enum logic [ST_W-1:0] {
        RUN      = 2'd0,
        LDUSE    = 2'd1,
        FLAGWAIT = 2'd2,
        MEMWAIT  = 2'd3
    } stall_state_t;

    localparam logic [REG_W-1:0] XZR = 5'd31;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// ID/EX hazard inputs and pipeline-register control outputs of pipeline_ctrl.
interface pipeline_ctrl_if;
    import pipe_pkg::*;

    logic             id_valid;
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rb;
    logic             id_uses_rn;
    logic             id_uses_rb;
    logic             id_is_uncond;
    logic             id_is_cbz;
    logic             id_is_bcond;
    logic             id_zero;
    logic             id_cond_true;
    logic             ex_memread;
    logic             ex_regwrite;
    logic [REG_W-1:0] ex_rd;
    logic             ex_setflags;
    logic             mem_busy;

    logic             pc_we;
    logic             pc_sel_branch;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             back_we;
    logic [ST_W-1:0]  state;

    // Controller side
    modport master (
        input  id_valid, id_rn, id_rb, id_uses_rn, id_uses_rb,
               id_is_uncond, id_is_cbz, id_is_bcond, id_zero, id_cond_true,
               ex_memread, ex_regwrite, ex_rd, ex_setflags, mem_busy,
        output pc_we, pc_sel_branch, ifid_we, ifid_flush, idex_bubble,
               back_we, state
    );

    // Datapath side
    modport slave (
        output id_valid, id_rn, id_rb, id_uses_rn, id_uses_rb,
               id_is_uncond, id_is_cbz, id_is_bcond, id_zero, id_cond_true,
               ex_memread, ex_regwrite, ex_rd, ex_setflags, mem_busy,
        input  pc_we, pc_sel_branch, ifid_we, ifid_flush, idex_bubble,
               back_we, state
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use, flag-dependency and taken-branch terms for the ID stage.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rb,
    input  logic             id_uses_rn,
    input  logic             id_uses_rb,
    input  logic             id_is_uncond,
    input  logic             id_is_cbz,
    input  logic             id_is_bcond,
    input  logic             id_zero,
    input  logic             id_cond_true,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_setflags,
    output logic             ldh_c,
    output logic             flh_c,
    output logic             taken_c
);

    logic rn_hit;
    logic rb_hit;

    // XZR reads as zero, so a load targeting it never creates a dependency
    assign rn_hit  = id_uses_rn & (id_rn == ex_rd);
    assign rb_hit  = id_uses_rb & (id_rb == ex_rd);
    assign ldh_c   = ex_memread & ex_regwrite & (ex_rd != XZR) & id_valid
                   & (rn_hit | rb_hit);
    assign flh_c   = id_valid & id_is_bcond & ex_setflags;
    assign taken_c = id_valid & (id_is_uncond | (id_is_cbz & id_zero)
                               | (id_is_bcond & id_cond_true));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/sequencing controller: enables, bubbles, fetch redirect, stall cause.
// Optional performance counters under PIPE_PERF_CNT_EN.
module pipeline_ctrl
    import pipe_pkg::*;
`ifdef PIPE_PERF_CNT_EN
#(
    parameter int unsigned CNT_W = 32
)
`endif
(
    input  logic             clk,
    input  logic             reset,
    pipeline_ctrl_if.master  pif
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    logic ldh;
    logic flh;
    logic taken;
    stall_state_t state_q;
    stall_state_t state_d;

    hazard_detect u_hazard_detect (
        .id_valid     (pif.id_valid),
        .id_rn        (pif.id_rn),
        .id_rb        (pif.id_rb),
        .id_uses_rn   (pif.id_uses_rn),
        .id_uses_rb   (pif.id_uses_rb),
        .id_is_uncond (pif.id_is_uncond),
        .id_is_cbz    (pif.id_is_cbz),
        .id_is_bcond  (pif.id_is_bcond),
        .id_zero      (pif.id_zero),
        .id_cond_true (pif.id_cond_true),
        .ex_memread   (pif.ex_memread),
        .ex_regwrite  (pif.ex_regwrite),
        .ex_rd        (pif.ex_rd),
        .ex_setflags  (pif.ex_setflags),
        .ldh_c        (ldh),
        .flh_c        (flh),
        .taken_c      (taken)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Decode always uses live hazard terms, so leaving MEMWAIT picks up a pending load-use at once
    always_comb begin
        state_d           = RUN;
        pif.pc_we         = 1'b1;
        pif.pc_sel_branch = 1'b0;
        pif.ifid_we       = 1'b1;
        pif.ifid_flush    = 1'b0;
        pif.idex_bubble   = 1'b0;
        pif.back_we       = 1'b1;
        if (pif.mem_busy) begin
            state_d     = MEMWAIT;
            pif.pc_we   = 1'b0;
            pif.ifid_we = 1'b0;
            pif.back_we = 1'b0;
        end else if (ldh || flh) begin
            state_d         = ldh ? LDUSE : FLAGWAIT;
            pif.pc_we       = 1'b0;
            pif.ifid_we     = 1'b0;
            pif.idex_bubble = 1'b1;
        end else if (taken) begin
            pif.pc_sel_branch = 1'b1;
            pif.ifid_flush    = 1'b1;
        end
    end

    assign pif.state = state_q;

`ifdef PIPE_PERF_CNT_EN
    // Free-running counters; wrap naturally at 2^CNT_W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (!pif.pc_we) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage 64-bit LEGv8 datapath. Each cycle it decides whether the PC, IF/ID, ID/EX and EX/MEM/WB registers advance, stall, or insert a bubble. It resolves load-use, flag-dependency and data-memory-busy hazards and redirects fetch on taken branches resolved in ID. It sits beside the forwarding unit, drives the pipeline-register enables, and tracks the active stall cause in a registered state.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters (present only with the macro below)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately
- id_valid  in  1  IF/ID holds a real instruction
- id_rn  in  5  ID first read register
- id_rb  in  5  ID second read register (the Reg2Loc-selected address)
- id_uses_rn, id_uses_rb  in  1 each  ID instruction reads that operand
- id_is_uncond  in  1  B/BL in ID
- id_is_cbz  in  1  CBZ in ID
- id_is_bcond  in  1  B.cond in ID
- id_zero  in  1  accelerated zero flag of the forwarded Db
- id_cond_true  in  1  condition of the B.cond is true against the committed flags
- ex_memread  in  1  EX instruction is LDUR/LDURB
- ex_regwrite  in  1  EX instruction writes a register
- ex_rd  in  5  EX destination register
- ex_setflags  in  1  EX instruction sets flags
- mem_busy  in  1  data memory not ready; the MEM stage must hold
- pc_we  out  1  PC register write enable
- pc_sel_branch  out  1  select the branch target into the PC
- ifid_we  out  1  IF/ID write enable
- ifid_flush  out  1  load a NOP into IF/ID
- idex_bubble  out  1  zero the control fields entering ID/EX
- back_we  out  1  EX/MEM and MEM/WB write enable
- state  out  2  current stall cause: RUN=0, LDUSE=1, FLAGWAIT=2, MEMWAIT=3
- cyc_cnt, stall_cnt  out  CNT_W each  performance counters (macro only)

## Operation
Hazard terms, evaluated combinationally each cycle:
- memh: mem_busy
- ldh: ex_memread & ex_regwrite & ex_rd≠31 & id_valid & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rb & id_rb==ex_rd))
- flh: id_valid & id_is_bcond & ex_setflags
- taken: id_valid & (id_is_uncond | (id_is_cbz & id_zero) | (id_is_bcond & id_cond_true))

Priority is memh > ldh > flh > taken.
- memh: all enables are 0 and there is no bubble or flush. The whole pipeline freezes. pc_sel_branch=0.
- ldh or flh: pc_we=0, ifid_we=0, idex_bubble=1, back_we=1. pc_sel_branch=0; the branch is masked while stalled.
- taken, with no hazard: pc_we=1, pc_sel_branch=1, ifid_we=1, ifid_flush=1, back_we=1.
- Otherwise: pc_we=ifid_we=back_we=1 and every other output 0.

The state register loads the highest-priority active cause: MEMWAIT, LDUSE, FLAGWAIT, or RUN.
- The state is informational; output decode uses the current inputs.
- Exception: when the state is MEMWAIT and mem_busy falls, the hazard terms are re-evaluated in that same cycle. A load-use pending behind the memory stall takes effect immediately, with no lost cycle.
- X31 (XZR) never causes a load-use stall.

## Timing
- All outputs are combinational from the inputs. There is no added latency; decisions apply at the edge that ends the current cycle.
- A load-use hazard costs exactly 1 bubble. A FLAGWAIT costs exactly 1 bubble. A taken branch costs exactly 1 flushed slot.
- MEMWAIT lasts exactly as many cycles as mem_busy is high.
- Reset (reset=0) values:
  - state = RUN
  - counters = 0
  - outputs follow the RUN decode of the current inputs
- Reset asserted mid-stall returns the state to RUN asynchronously. No pending cause is remembered.
- With ldh and flh both true, the cycle is charged to LDUSE.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - cyc_cnt increments every cycle out of reset.
  - stall_cnt increments on every cycle where pc_we=0.
  - Both wrap at 2^CNT_W without saturating.
- PIPE_PERF_CNT_EN undefined: neither the counters nor their ports exist.

## Structure
- The shared package pipe_pkg holds:
  - typedef enum logic [1:0] stall_state_t {RUN, LDUSE, FLAGWAIT, MEMWAIT}
  - localparam XZR = 5'd31
- One sub-module, hazard_detect, holds the purely combinational ldh/flh/taken terms. pipeline_ctrl holds the state register, priority decode and counters.

## Test plan
- LDUR X1 in EX (ex_rd=1, ex_memread=1), ADD in ID reading id_rn=1 -> one cycle with pc_we=0, ifid_we=0, idex_bubble=1, state=LDUSE next edge; following cycle all enables 1.
- Same with ex_rd=31 -> no stall, state stays RUN.
- SUBS in EX (ex_setflags=1), B.cond in ID with id_cond_true=1 -> FLAGWAIT bubble with pc_sel_branch=0; next cycle pc_sel_branch=1, ifid_flush=1.
- CBZ in ID with id_zero=1 -> pc_sel_branch=1, ifid_flush=1, idex_bubble=0; with id_zero=0 -> pc_sel_branch=0.
- mem_busy high 3 cycles while a load-use is pending -> 3 cycles with all enables 0 and state=MEMWAIT; on the falling cycle idex_bubble=1 immediately; with PIPE_PERF_CNT_EN defined, stall_cnt=4.
- reset pulsed low during MEMWAIT -> state=RUN asynchronously, cyc_cnt=stall_cnt=0.
